// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: word/byte-enable
// typedefs, the access FSM state encoding and lane-mask constants.
package dmem_access_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [1:0]        lc3b_byte_en;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_BUSY,
    DM_DONE
  } dmem_state_t;

  localparam lc3b_byte_en BE_WORD = 2'b11;
  localparam lc3b_byte_en BE_LO   = 2'b01;
  localparam lc3b_byte_en BE_HI   = 2'b10;

endpackage

// File: rtl/dmem_access_ctrl_byte_lane.sv
// Combinational byte-lane steering for LDB/STB versus word accesses.
// Request side (address, write data, lane mask) is steered from the
// incoming request; response side (load data) from the latched access.
module dmem_access_ctrl_byte_lane
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output lc3b_byte_en       mem_byte_en,
  input  logic              rsp_byte,
  input  logic              rsp_hi,
  input  logic [DATA_W-1:0] rsp_raw,
  output logic [DATA_W-1:0] rsp_data
);

  // Request steering: byte accesses keep the byte address and replicate the
  // low store byte on both lanes; word accesses are forced even-aligned.
  always_comb begin
    if (req_byte) begin
      mem_addr    = req_addr;
      mem_wdata   = {req_wdata[BYTE_W-1:0], req_wdata[BYTE_W-1:0]};
      mem_byte_en = req_addr[0] ? BE_HI : BE_LO;
    end else begin
      mem_addr    = {req_addr[ADDR_W-1:1], 1'b0};
      mem_wdata   = req_wdata;
      mem_byte_en = BE_WORD;
    end
  end

  // Response steering: pick the addressed byte and zero-extend it for LDB.
  always_comb begin
    if (rsp_byte) begin
      rsp_data = {{(DATA_W-BYTE_W){1'b0}},
                  rsp_hi ? rsp_raw[DATA_W-1:BYTE_W] : rsp_raw[BYTE_W-1:0]};
    end else begin
      rsp_data = rsp_raw;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller. Converts one pipelined
// load/store into a held dmem_read/dmem_write handshake, stalls the
// pipeline until the cache responds, then presents the result until the
// downstream stage accepts it.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              ctrl_read,
  input  logic              ctrl_write,
  input  logic              ctrl_byte,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              advance,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output lc3b_byte_en       dmem_byte_enable,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata
);

  dmem_state_t       state_q;
  dmem_state_t       state_d;
  logic              new_req;
  logic              byte_p1;
  logic [ADDR_W-1:0] lane_addr;
  logic [DATA_W-1:0] lane_wdata;
  lc3b_byte_en       lane_be;
  logic [DATA_W-1:0] lane_rdata;

  assign new_req = req_valid & (ctrl_read | ctrl_write);

  // For byte accesses the issued address is unmodified, so its bit 0 still
  // selects the lane; for word accesses rsp_hi is a don't-care.
  dmem_access_ctrl_byte_lane #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_byte_lane (
    .req_byte    (ctrl_byte),
    .req_addr    (addr_in),
    .req_wdata   (wdata_in),
    .mem_addr    (lane_addr),
    .mem_wdata   (lane_wdata),
    .mem_byte_en (lane_be),
    .rsp_byte    (byte_p1),
    .rsp_hi      (dmem_addr[0]),
    .rsp_raw     (dmem_rdata),
    .rsp_data    (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs toward the pipeline.
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      DM_IDLE: begin
        stall = new_req;
        if (new_req) state_d = DM_BUSY;
      end
      DM_BUSY: begin
        stall = 1'b1;
        if (dmem_resp) state_d = DM_DONE;
      end
      DM_DONE: begin
        rdata_valid = 1'b1;
        if (advance) state_d = DM_IDLE;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  // Registered cache interface and load result. A read takes priority when
  // both read and write are requested; the write is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= 2'b00;
      rdata_out        <= '0;
      byte_p1          <= 1'b0;
    end else begin
      case (state_q)
        DM_IDLE: begin
          if (new_req) begin
            dmem_read        <= ctrl_read;
            dmem_write       <= ctrl_write & ~ctrl_read;
            dmem_addr        <= lane_addr;
            dmem_wdata       <= lane_wdata;
            dmem_byte_enable <= lane_be;
            byte_p1          <= ctrl_byte;
          end
        end
        DM_BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            rdata_out  <= lane_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized
// load/store transactions compared against a transaction-level model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, ctrl_read, ctrl_write, ctrl_byte;
  logic [15:0] addr_in, wdata_in;
  logic        advance;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .ctrl_read        (ctrl_read),
    .ctrl_write       (ctrl_write),
    .ctrl_byte        (ctrl_byte),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .advance          (advance),
    .stall            (stall),
    .rdata_out        (rdata_out),
    .rdata_valid      (rdata_valid),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    ctrl_read  = 1'b0;
    ctrl_write = 1'b0;
    ctrl_byte  = 1'b0;
    advance    = 1'b0;
    dmem_resp  = 1'b0;
  endtask

  // One complete transaction, issued from IDLE. The expected cache request
  // and load result are derived from the addressing rules with arithmetic.
  task automatic do_access(input bit rd, input bit wr, input bit byt,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int resp_dly,
                           input int hold_done);
    bit          exp_rd, exp_wr;
    logic [15:0] exp_addr, exp_wd, exp_load;
    logic [1:0]  exp_be;
    exp_rd   = rd;
    exp_wr   = wr && !rd;
    exp_addr = byt ? addr : (addr & 16'hFFFE);
    exp_be   = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_wd   = byt ? ((wdata & 16'h00FF) * 16'h0101) : wdata;
    exp_load = byt ? ((rdata >> (addr[0] ? 8 : 0)) & 16'h00FF) : rdata;

    req_valid  = 1'b1;
    ctrl_read  = rd;
    ctrl_write = wr;
    ctrl_byte  = byt;
    addr_in    = addr;
    wdata_in   = wdata;
    advance    = 1'b0;
    dmem_resp  = 1'b0;
    @(negedge clk);
    check_eq("req_stall", stall, 1'b1);
    check_eq("req_no_early_read", dmem_read | dmem_write, 1'b0);

    for (int c = 1; c <= resp_dly; c++) begin
      step();
      addr_in    = 16'($urandom);
      wdata_in   = 16'($urandom);
      dmem_resp  = (c == resp_dly);
      dmem_rdata = (c == resp_dly) ? rdata : 16'($urandom);
      @(negedge clk);
      check_eq("busy_read", dmem_read, exp_rd);
      check_eq("busy_write", dmem_write, exp_wr);
      check_eq("busy_addr", dmem_addr, exp_addr);
      check_eq("busy_be", dmem_byte_enable, exp_be);
      if (exp_wr) check_eq("busy_wdata", dmem_wdata, exp_wd);
      check_eq("busy_stall", stall, 1'b1);
      check_eq("busy_rvalid", rdata_valid, 1'b0);
    end

    for (int h = 0; h <= hold_done; h++) begin
      step();
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      advance    = (h == hold_done);
      @(negedge clk);
      check_eq("done_stall", stall, 1'b0);
      check_eq("done_rvalid", rdata_valid, 1'b1);
      check_eq("done_no_reissue", dmem_read | dmem_write, 1'b0);
      if (exp_rd) check_eq("done_rdata", rdata_out, exp_load);
    end

    step();
    idle_inputs();
    @(negedge clk);
    check_eq("idle_rvalid", rdata_valid, 1'b0);
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_no_req", dmem_read | dmem_write, 1'b0);
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n      = 1'b0;
    addr_in    = 16'h0;
    wdata_in   = 16'h0;
    dmem_rdata = 16'h0;
    step();
    step();
    @(negedge clk);
    check_eq("rst_read", dmem_read, 1'b0);
    check_eq("rst_write", dmem_write, 1'b0);
    check_eq("rst_addr", dmem_addr, 16'h0);
    check_eq("rst_wdata", dmem_wdata, 16'h0);
    check_eq("rst_be", dmem_byte_enable, 2'b00);
    check_eq("rst_rdata", rdata_out, 16'h0);
    check_eq("rst_rvalid", rdata_valid, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Non-memory instruction passes without stalling or issuing.
    req_valid = 1'b1;
    @(negedge clk);
    check_eq("nonmem_stall", stall, 1'b0);
    step();
    @(negedge clk);
    check_eq("nonmem_no_req", dmem_read | dmem_write, 1'b0);
    check_eq("nonmem_rvalid", rdata_valid, 1'b0);
    idle_inputs();
    step();

    // Directed cases.
    do_access(1, 0, 0, 16'h3000, 16'h0000, 16'hBEEF, 2, 0);
    do_access(1, 0, 1, 16'h3001, 16'h0000, 16'hA55A, 1, 0);
    do_access(1, 0, 1, 16'h3000, 16'h0000, 16'hA55A, 3, 0);
    do_access(0, 1, 1, 16'h4001, 16'h1234, 16'h0000, 2, 0);
    do_access(0, 1, 0, 16'h4003, 16'hCAFE, 16'h0000, 2, 1);
    do_access(1, 0, 0, 16'h5554, 16'h0000, 16'h1357, 1, 4);
    do_access(1, 1, 0, 16'h6001, 16'hFFFF, 16'h2468, 2, 0);

    // Reset in BUSY abandons the access; a later response is ignored.
    req_valid = 1'b1;
    ctrl_read = 1'b1;
    addr_in   = 16'h5000;
    step();
    idle_inputs();
    @(negedge clk);
    check_eq("rstbusy_read_before", dmem_read, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hFFFF;
    @(negedge clk);
    check_eq("rstbusy_read", dmem_read, 1'b0);
    check_eq("rstbusy_addr", dmem_addr, 16'h0);
    check_eq("rstbusy_rvalid", rdata_valid, 1'b0);
    step();
    dmem_resp = 1'b0;
    @(negedge clk);
    check_eq("rstbusy_resp_ignored", rdata_valid, 1'b0);
    check_eq("rstbusy_rdata", rdata_out, 16'h0);
    check_eq("rstbusy_stall", stall, 1'b0);
    step();

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      bit rd, wr, byt;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      byt = 1'($urandom_range(0, 1));
      do_access(rd, wr, byt, 16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
